// File: rtl/cond_unit_pkg.sv
// Shared definitions for the processor status / branch-condition block:
// condition-code encodings, PSR bit positions and a flag packing helper.
package cond_unit_pkg;

    localparam int PSR_W = 5;

    localparam int PSR_C = 4;
    localparam int PSR_L = 3;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_N = 0;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_HI = 4'b0100;
    localparam logic [3:0] COND_LS = 4'b0101;
    localparam logic [3:0] COND_GT = 4'b0110;
    localparam logic [3:0] COND_LE = 4'b0111;
    localparam logic [3:0] COND_FS = 4'b1000;
    localparam logic [3:0] COND_FC = 4'b1001;
    localparam logic [3:0] COND_LO = 4'b1010;
    localparam logic [3:0] COND_HS = 4'b1011;
    localparam logic [3:0] COND_LT = 4'b1100;
    localparam logic [3:0] COND_GE = 4'b1101;
    localparam logic [3:0] COND_UC = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef logic [PSR_W-1:0] psr_t;

    function automatic psr_t pack_flags(input logic c, input logic l, input logic f,
                                        input logic z, input logic n);
        psr_t p;
        p        = '0;
        p[PSR_C] = c;
        p[PSR_L] = l;
        p[PSR_F] = f;
        p[PSR_Z] = z;
        p[PSR_N] = n;
        return p;
    endfunction

endpackage

// File: rtl/cond_unit_eval.sv
// Combinational branch-condition evaluator: 4-bit condition code against a PSR.
// Kept standalone so the controller can reuse it for its own decisions.
module cond_eval
    import cond_unit_pkg::*;
(
    input  logic [4:0] psr,
    input  logic [3:0] cond,
    output logic       taken
);

    logic c, l, f, z, n;

    always_comb begin
        c = psr[PSR_C];
        l = psr[PSR_L];
        f = psr[PSR_F];
        z = psr[PSR_Z];
        n = psr[PSR_N];
    end

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_CS: taken = c;
            COND_CC: taken = ~c;
            COND_HI: taken = l;
            COND_LS: taken = ~l;
            COND_GT: taken = n;
            COND_LE: taken = ~n;
            COND_FS: taken = f;
            COND_FC: taken = ~f;
            COND_LO: taken = ~l & ~z;
            COND_HS: taken = l | z;
            COND_LT: taken = ~n & ~z;
            COND_GE: taken = n | z;
            COND_UC: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Registered PSR, branch-condition evaluation and PSR save stack for interrupts.
// Optional COND_BYPASS_EN: evaluate on incoming flags when flag_we coincides with br_valid.
module cond_unit
    import cond_unit_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_in,
    input  logic          l_in,
    input  logic          f_in,
    input  logic          z_in,
    input  logic          n_in,
    input  logic          flag_we,
    input  logic          br_valid,
    input  logic [3:0]    cond,
    input  logic          psr_push,
    input  logic          psr_pop,
    output logic [4:0]    psr,
    output logic          taken,
    output logic          taken_valid,
    output logic [CW-1:0] stk_count,
    output logic          stk_err
);

    psr_t          stk [DEPTH];
    psr_t          flags;
    psr_t          top_val;
    psr_t          psr_next;
    psr_t          eval_src;
    logic [CW-1:0] top_idx;
    logic [CW-1:0] wr_idx;
    logic [CW-1:0] count_next;
    logic          nonempty;
    logic          full;
    logic          pop_ok;
    logic          push_ok;
    logic          err_set;
    logic          eval_taken;

    always_comb begin
        flags    = pack_flags(c_in, l_in, f_in, z_in, n_in);
        nonempty = (stk_count != '0);
        full     = (stk_count == CW'(DEPTH));
        top_idx  = stk_count - 1'b1;
        pop_ok   = psr_pop & nonempty;
        // A push paired with a good pop overwrites the top entry, so full is no obstacle.
        push_ok  = psr_push & (pop_ok | ~full);
        wr_idx   = pop_ok ? top_idx : stk_count;
        err_set  = (psr_push & ~pop_ok & full) | (psr_pop & ~nonempty & ~psr_push);
    end

    always_comb begin
        top_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (top_idx == CW'(i)) top_val = stk[i];
        end
    end

    always_comb begin
        count_next = stk_count;
        if (pop_ok && !psr_push)       count_next = stk_count - 1'b1;
        else if (push_ok && !pop_ok)   count_next = stk_count + 1'b1;
    end

    always_comb begin
        psr_next = psr;
        if (pop_ok)       psr_next = top_val;
        else if (flag_we) psr_next = flags;
    end

    always_comb begin
        eval_src = psr;
`ifdef COND_BYPASS_EN
        if (flag_we) eval_src = pop_ok ? top_val : flags;
`endif
    end

    cond_eval u_eval (
        .psr   (eval_src),
        .cond  (cond),
        .taken (eval_taken)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            psr         <= '0;
            taken       <= 1'b0;
            taken_valid <= 1'b0;
            stk_count   <= '0;
            stk_err     <= 1'b0;
        end else begin
            psr         <= psr_next;
            taken_valid <= br_valid;
            if (br_valid) taken <= eval_taken;
            stk_count   <= count_next;
            if (err_set) stk_err <= 1'b1;
        end
    end

    // Stack contents are don't-care after reset, so no reset on the array.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == CW'(i)) stk[i] <= psr;
            end
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed steps plus randomized traffic
// compared against a queue-based reference model of the status/branch block.
module tb_cond_unit;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          c_in, l_in, f_in, z_in, n_in;
    logic          flag_we, br_valid, psr_push, psr_pop;
    logic [3:0]    cond;
    logic [4:0]    psr;
    logic          taken, taken_valid, stk_err;
    logic [CW-1:0] stk_count;

    int checks = 0;
    int errors = 0;

    logic [4:0] m_psr;
    logic [4:0] m_q[$];
    logic       m_err, m_taken, m_tv;

    cond_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .c_in(c_in), .l_in(l_in), .f_in(f_in), .z_in(z_in), .n_in(n_in),
        .flag_we(flag_we), .br_valid(br_valid), .cond(cond),
        .psr_push(psr_push), .psr_pop(psr_pop),
        .psr(psr), .taken(taken), .taken_valid(taken_valid),
        .stk_count(stk_count), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    // Condition table: codes 0-9 pick one flag (odd = inverted), 10-13 are
    // "flag or zero" groups (odd = the OR form), 14 always, 15 never.
    function automatic logic ref_eval(input logic [4:0] p, input logic [3:0] cc);
        logic single [5];
        logic base;
        single[0] = p[1];  // Z
        single[1] = p[4];  // C
        single[2] = p[3];  // L
        single[3] = p[0];  // N
        single[4] = p[2];  // F
        if (cc < 10)       return single[cc / 2] ^ cc[0];
        else if (cc < 14) begin
            base = (cc < 12) ? (p[3] | p[1]) : (p[0] | p[1]);
            return cc[0] ? base : !base;
        end
        else               return (cc == 14);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic fw, input logic [4:0] fl,
                         input logic bv, input logic [3:0] cc,
                         input logic pu, input logic po);
        reset    = r;
        flag_we  = fw;
        {c_in, l_in, f_in, z_in, n_in} = fl;
        br_valid = bv;
        cond     = cc;
        psr_push = pu;
        psr_pop  = po;
    endtask

    // Advance one clock: update the model from the applied inputs, then compare.
    task automatic cycle();
        logic [4:0] old, fl, top, src;
        logic       popped;
        if (reset) begin
            m_psr = '0; m_q.delete(); m_err = 1'b0; m_taken = 1'b0; m_tv = 1'b0;
        end else begin
            old    = m_psr;
            fl     = {c_in, l_in, f_in, z_in, n_in};
            popped = psr_pop && (m_q.size() > 0);
            top    = popped ? m_q[m_q.size()-1] : 5'd0;
            src    = old;
`ifdef COND_BYPASS_EN
            if (flag_we) src = popped ? top : fl;
`endif
            m_tv = br_valid;
            if (br_valid) m_taken = ref_eval(src, cond);
            if (popped) begin
                if (psr_push) m_q[m_q.size()-1] = old;
                else          void'(m_q.pop_back());
                m_psr = top;
            end else begin
                if (psr_pop && !psr_push) m_err = 1'b1;
                if (psr_push) begin
                    if (m_q.size() < DEPTH) m_q.push_back(old);
                    else                    m_err = 1'b1;
                end
                if (flag_we) m_psr = fl;
            end
        end
        @(posedge clk);
        #1;
        chk("psr",         8'(psr),         8'(m_psr));
        chk("taken_valid", 8'(taken_valid), 8'(m_tv));
        chk("taken",       8'(taken),       8'(m_taken));
        chk("stk_count",   8'(stk_count),   8'(m_q.size()));
        chk("stk_err",     8'(stk_err),     8'(m_err));
    endtask

    initial begin
        logic bypass_exp;
`ifdef COND_BYPASS_EN
        bypass_exp = 1'b1;
`else
        bypass_exp = 1'b0;
`endif
        m_psr = '0; m_err = 1'b0; m_taken = 1'b0; m_tv = 1'b0;

        drive(1, 0, 5'b00000, 0, 4'd0, 0, 0); cycle(); cycle();
        chk("reset_psr", 8'(psr), 8'h00);
        chk("reset_tv",  8'(taken_valid), 8'h00);

        drive(0, 0, 5'b00000, 1, 4'b1110, 0, 0); cycle();
        chk("uc_tv", 8'(taken_valid), 8'h01);
        chk("uc_taken", 8'(taken), 8'h01);
        drive(0, 0, 5'b00000, 1, 4'b1111, 0, 0); cycle();
        chk("nv_taken", 8'(taken), 8'h00);
        drive(0, 0, 5'b00000, 0, 4'b1110, 0, 0); cycle();
        chk("idle_tv", 8'(taken_valid), 8'h00);
        chk("idle_hold", 8'(taken), 8'h00);

        drive(0, 1, 5'b00010, 0, 4'd0, 0, 0); cycle();
        chk("load_z", 8'(psr), 8'h02);
        drive(0, 0, 5'b00000, 1, 4'b0000, 0, 0); cycle();
        chk("eq_z", 8'(taken), 8'h01);
        drive(0, 0, 5'b00000, 1, 4'b0001, 0, 0); cycle();
        chk("ne_z", 8'(taken), 8'h00);
        drive(0, 1, 5'b01000, 0, 4'd0, 0, 0); cycle();
        drive(0, 0, 5'b00000, 1, 4'b1011, 0, 0); cycle();
        chk("hs_l", 8'(taken), 8'h01);
        drive(0, 0, 5'b00000, 1, 4'b1010, 0, 0); cycle();
        chk("lo_l", 8'(taken), 8'h00);

        drive(1, 0, 5'b00000, 0, 4'd0, 0, 0); cycle();
        drive(0, 1, 5'b00010, 1, 4'b0000, 0, 0); cycle();
        chk("bypass_eq", 8'(taken), 8'(bypass_exp));

        drive(0, 1, 5'b10000, 0, 4'd0, 0, 0); cycle();
        drive(0, 0, 5'b00000, 0, 4'd0, 1, 0); cycle();
        chk("push_cnt", 8'(stk_count), 8'h01);
        drive(0, 1, 5'b00001, 0, 4'd0, 0, 0); cycle();
        drive(0, 0, 5'b00000, 0, 4'd0, 0, 1); cycle();
        chk("pop_psr", 8'(psr), 8'h10);
        chk("pop_cnt", 8'(stk_count), 8'h00);
        drive(0, 1, 5'b00001, 0, 4'd0, 1, 0); cycle();
        chk("pushwe_psr", 8'(psr), 8'h01);
        drive(0, 0, 5'b00000, 0, 4'd0, 0, 1); cycle();
        chk("pushwe_old", 8'(psr), 8'h10);

        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 5'b00000, 0, 4'd0, 1, 0); cycle();
        end
        chk("ovf_cnt", 8'(stk_count), 8'h04);
        chk("ovf_err", 8'(stk_err), 8'h01);

        drive(1, 0, 5'b00000, 0, 4'd0, 0, 0); cycle();
        drive(0, 1, 5'b00010, 0, 4'd0, 0, 0); cycle();
        drive(0, 0, 5'b00000, 0, 4'd0, 0, 1); cycle();
        chk("udf_err", 8'(stk_err), 8'h01);
        chk("udf_psr", 8'(psr), 8'h02);

        drive(0, 0, 5'b00000, 0, 4'd0, 1, 0); cycle();
        drive(0, 0, 5'b00000, 1, 4'b1110, 0, 0); cycle();
        drive(1, 1, 5'b11111, 1, 4'b1110, 1, 0); cycle();
        chk("rst_tv",  8'(taken_valid), 8'h00);
        chk("rst_psr", 8'(psr), 8'h00);
        chk("rst_cnt", 8'(stk_count), 8'h00);

        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 63) == 0),
                  $urandom_range(0, 1) == 1,
                  5'($urandom),
                  $urandom_range(0, 4) < 3,
                  4'($urandom),
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
# cond_unit

Processor status and branch-condition block that consumes the five ALU flags (C, L, F, Z, N). It holds them in a registered PSR, evaluates 4-bit branch/jump condition codes against that PSR, and saves/restores the PSR on a small stack for interrupt entry and return. It sits between the ALU flag outputs and the controller's PC-select logic.

## Interface
- DEPTH, 4: PSR save-stack entries (≥1).
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- c_in, l_in, f_in, z_in, n_in  in  1 each  ALU flags of the current instruction.
- flag_we  in  1  capture the ALU flags into the PSR this cycle.
- br_valid  in  1  a condition evaluation is requested this cycle.
- cond  in  4  condition code, sampled with br_valid.
- psr_push  in  1  save the PSR (interrupt entry).
- psr_pop  in  1  restore the PSR (interrupt return).
- psr  out  5  registered flags {C,L,F,Z,N} (bit 4 = C, bit 0 = N).
- taken  out  1  evaluation result, qualified by taken_valid.
- taken_valid  out  1  one-cycle pulse per accepted br_valid.
- stk_count  out  clog2(DEPTH+1)  occupied stack entries.
- stk_err  out  1  sticky overflow/underflow flag.

## Operation
- Reset values: psr=0, taken=0, taken_valid=0, stk_count=0, stk_err=0, stack contents don't-care.
- PSR update priority per cycle: psr_pop (non-empty) > flag_we > hold.
- psr_push saves the PSR value from before the edge. When push and flag_we occur in the same cycle, the old PSR is pushed and the new flags are written.
- Push and pop in the same cycle: PSR is loaded from the top entry, the incoming value replaces that entry, and stk_count is unchanged. This is legal at full or empty depth. When the stack is empty, pop is a no-op and the push proceeds.
- Push with stk_count==DEPTH: the push is dropped, stk_err is set, and the PSR is still updatable by flag_we.
- Pop with stk_count==0: the pop is dropped, stk_err is set, and the PSR follows flag_we.
- stk_err clears only on reset.
- Condition codes:
  - EQ 0000 Z; NE 0001 !Z
  - CS 0010 C; CC 0011 !C
  - HI 0100 L; LS 0101 !L
  - GT 0110 N; LE 0111 !N
  - FS 1000 F; FC 1001 !F
  - LO 1010 !L&!Z; HS 1011 L|Z
  - LT 1100 !N&!Z; GE 1101 N|Z
  - UC 1110 1; 1111 never (taken=0)
- When br_valid=0, taken_valid=0 and taken holds its last value.

## Timing
- PSR write latency: flags presented with flag_we at edge k are visible on psr after edge k.
- Evaluation latency: br_valid at cycle t produces taken/taken_valid registered at edge t+1, so they are valid during cycle t+1.
- Back-to-back br_valid is accepted every cycle with no stall. There is no ready signal.
- The flag source for evaluation is the PSR as registered during cycle t, unless the bypass described under Configuration is enabled.
- reset asserted mid-operation overrides every input on that edge. A pending taken_valid is not issued.

## Configuration
- COND_BYPASS_EN defined: when flag_we and br_valid coincide in cycle t, the condition is evaluated on the incoming c_in..n_in. This allows a CMP immediately followed by a branch with no bubble. A simultaneous successful pop takes precedence: the bypass then uses the popped value.
- COND_BYPASS_EN undefined: evaluation always uses the registered psr. The controller must insert one cycle between a flag-setting instruction and a dependent branch.

## Structure
- Shared package holds:
  - condition-code localparams (COND_EQ … COND_NV);
  - PSR bit indices (PSR_C=4, PSR_L=3, PSR_F=2, PSR_Z=1, PSR_N=0).
- Sub-module cond_eval: purely combinational, inputs psr[4:0] and cond[3:0], output taken. It is instantiated once and reusable by the controller.
- The stack is a register array with a count pointer. No RAM macro is used.

## Test plan
- Reset, then br_valid with cond=1110 → taken_valid=1 and taken=1 at t+1. With cond=1111 → taken=0. psr=0 after reset.
- flag_we with Z=1 (psr=00010), then EQ → taken=1, and NE → taken=0. Load L=1,Z=0, then HS → 1 and LO → 0.
- Same cycle flag_we(Z=1) + br_valid EQ, starting from psr=0 → taken=1 with COND_BYPASS_EN defined, taken=0 without it.
- Load psr=10000 (C), push, load psr=00001 (N), pop → psr=10000 and stk_count goes 0→1→0. Push simultaneous with flag_we → the pushed entry is the old value.
- DEPTH=4: five pushes → stk_count=4 and stk_err=1. Reset, then pop on empty → stk_err=1 and psr unchanged.
- Assert reset in the cycle after a br_valid → taken_valid=0, psr=0, stk_count=0.
